vga_timing_ctrl: RTL and testbench

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

---
 rtl/vga_timing_ctrl.sv | 162 ++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator with a two-stage output pipeline.
// Drives sync, display enable, pixel data and a frame start pulse.
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk_v,
    input  logic        reset_v,
    input  logic        en_i,
    input  logic        self_test_i,
    output logic        data_req_o,
    input  logic [11:0] data_i,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic [11:0] rgb_o,
    output logic        frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          test_q, test_d;

    logic          de1_q, de1_d;
    logic          hs1_q, hs1_d;
    logic          vs1_q, vs1_d;
    logic          fs1_q, fs1_d;
    logic          tm1_q, tm1_d;
    logic [11:0]   bar1_q, bar1_d;

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          fs_q, fs_d;
    logic [11:0]   rgb_q, rgb_d;

    logic          at_origin;
    logic          visible;
    logic          test_eff;
    logic [2:0]    bar_idx;

    // Decode of the registered counters; a test request seen at (0,0)
    // must already govern the first pixel of that frame.
    always_comb begin
        at_origin  = (h_q == '0) && (v_q == '0);
        visible    = (h_q < H_VIS) && (v_q < V_VIS);
        test_eff   = at_origin ? self_test_i : test_q;
        data_req_o = ~reset_v & en_i & visible & ~test_eff;
    end

    // Counter and test-latch next state; disable parks at the origin.
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        test_d = test_eff;
        if (!en_i) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    // First pipeline stage: region flags and colour-bar selection.
    always_comb begin
        bar_idx = 3'(int'(h_q) / BAR_W);
        de1_d   = en_i & visible;
        hs1_d   = en_i & (h_q >= H_SS) & (h_q < H_SE);
        vs1_d   = en_i & (v_q >= V_SS) & (v_q < V_SE);
        fs1_d   = en_i & at_origin;
        tm1_d   = test_eff;
        case (bar_idx)
            3'd0:    bar1_d = 12'hfff;
            3'd1:    bar1_d = 12'hff0;
            3'd2:    bar1_d = 12'h0ff;
            3'd3:    bar1_d = 12'h0f0;
            3'd4:    bar1_d = 12'hf0f;
            3'd5:    bar1_d = 12'hf00;
            3'd6:    bar1_d = 12'h00f;
            default: bar1_d = 12'h000;
        endcase
    end

    // Second pipeline stage: sync polarity and pixel source select.
    always_comb begin
        hsync_d = hs1_q ? SYNC_POL : ~SYNC_POL;
        vsync_d = vs1_q ? SYNC_POL : ~SYNC_POL;
        de_d    = de1_q;
        fs_d    = fs1_q;
        rgb_d   = 12'h000;
        if (de1_q) begin
            rgb_d = tm1_q ? bar1_q : data_i;
        end
    end

    // State registers with synchronous reset to an idle, blank output.
    always_ff @(posedge clk_v) begin
        if (reset_v) begin
            h_q     <= '0;
            v_q     <= '0;
            test_q  <= 1'b0;
            de1_q   <= 1'b0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            fs1_q   <= 1'b0;
            tm1_q   <= 1'b0;
            bar1_q  <= 12'h000;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            rgb_q   <= 12'h000;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            test_q  <= test_d;
            de1_q   <= de1_d;
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            fs1_q   <= fs1_d;
            tm1_q   <= tm1_d;
            bar1_q  <= bar1_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign rgb_o         = rgb_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a reduced 24x8 raster.
// Covers normal, colour-bar, disable and mid-frame reset cases.
module tb_vga_timing_ctrl;

    localparam int NC = 800;

    logic        clk_v = 1'b0;
    logic        reset_v;
    logic        en_i;
    logic        self_test_i;
    logic [11:0] data_i;
    logic        data_req_o, hsync_o, vsync_o, de_o, frame_start_o;
    logic [11:0] rgb_o;
    logic        p_req, p_hs, p_vs, p_de, p_fs;
    logic [11:0] p_rgb;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit rs  [NC];
    bit en  [NC];
    bit st  [NC];
    bit tst [NC];
    bit vis [NC];
    int hh  [NC];
    int vv  [NC];

    always #5 clk_v = ~clk_v;

    vga_timing_ctrl #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0)
    ) u_dut (
        .clk_v(clk_v), .reset_v(reset_v), .en_i(en_i),
        .self_test_i(self_test_i), .data_req_o(data_req_o),
        .data_i(data_i), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .de_o(de_o), .rgb_o(rgb_o), .frame_start_o(frame_start_o)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1)
    ) u_dut_p (
        .clk_v(clk_v), .reset_v(reset_v), .en_i(en_i),
        .self_test_i(self_test_i), .data_req_o(p_req),
        .data_i(data_i), .hsync_o(p_hs), .vsync_o(p_vs),
        .de_o(p_de), .rgb_o(p_rgb), .frame_start_o(p_fs)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [11:0] stamp(input int m);
        return 12'((m * 37 + 5) % 4096);
    endfunction

    function automatic logic [11:0] bar(input int idx);
        case (idx)
            0: return 12'hfff;
            1: return 12'hff0;
            2: return 12'h0ff;
            3: return 12'h0f0;
            4: return 12'hf0f;
            5: return 12'hf00;
            6: return 12'h00f;
            default: return 12'h000;
        endcase
    endfunction

    initial begin
        int  cnt0, cnt1, j;
        bit  prev, valid, ah, av, ade, afs;
        logic [11:0] ergb;
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < NC; k++) begin
            cyc   = k;
            rs[k] = (k < 4) || (k >= 590 && k <= 592);
            en[k] = !(k >= 441 && k <= 450);
            st[k] = (k >= 60 && k < 250);
            reset_v     = rs[k];
            en_i        = en[k];
            self_test_i = st[k];
            data_i      = stamp(k);

            if (k == 0 || rs[k-1] || !en[k-1]) begin
                hh[k] = 0;
                vv[k] = 0;
            end else if (hh[k-1] == 23) begin
                hh[k] = 0;
                vv[k] = (vv[k-1] == 7) ? 0 : vv[k-1] + 1;
            end else begin
                hh[k] = hh[k-1] + 1;
                vv[k] = vv[k-1];
            end
            prev   = (k == 0 || rs[k-1]) ? 1'b0 : tst[k-1];
            tst[k] = (hh[k] == 0 && vv[k] == 0) ? st[k] : prev;
            vis[k] = (hh[k] < 16) && (vv[k] < 4);

            #1;
            chk("req", 32'(data_req_o),
                32'(!rs[k] && en[k] && vis[k] && !tst[k]));
            chk("req_p", 32'(p_req),
                32'(!rs[k] && en[k] && vis[k] && !tst[k]));

            if (k >= 1) begin
                valid = (k >= 2) && !rs[k-1] && !rs[k-2];
                ah = 1'b0; av = 1'b0; ade = 1'b0; afs = 1'b0;
                ergb = 12'h000;
                if (valid) begin
                    j   = k - 2;
                    ah  = en[j] && hh[j] >= 18 && hh[j] < 21;
                    av  = en[j] && vv[j] >= 5 && vv[j] < 7;
                    ade = en[j] && vis[j];
                    afs = en[j] && hh[j] == 0 && vv[j] == 0;
                    if (ade)
                        ergb = tst[j] ? bar(hh[j] / 2) : stamp(k - 1);
                end
                chk("hsync", 32'(hsync_o), 32'(!ah));
                chk("vsync", 32'(vsync_o), 32'(!av));
                chk("de", 32'(de_o), 32'(ade));
                chk("rgb", 32'(rgb_o), 32'(ergb));
                chk("fs", 32'(frame_start_o), 32'(afs));
                chk("hsync_p", 32'(p_hs), 32'(ah));
                chk("vsync_p", 32'(p_vs), 32'(av));
                chk("de_p", 32'(p_de), 32'(ade));
                chk("fs_p", 32'(p_fs), 32'(afs));
            end

            if (k == 196) chk("req_cnt_f0", 32'(cnt0), 32'd64);
            if (k == 388) chk("req_cnt_f1", 32'(cnt1), 32'd0);
            if (k >= 4 && k <= 195 && data_req_o === 1'b1) cnt0++;
            if (k >= 196 && k <= 387 && data_req_o === 1'b1) cnt1++;

            @(posedge clk_v);
            #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
